// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: fetch FSM encoding, NOP constant and default reset PC
package instr_fetch_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_DRAIN} fetch_state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch with a one-entry decode slot
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        pc_misalign
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, id_pc_q, id_pc_d, id_pc4_q, id_pc4_d;
  logic valid_q, valid_d, misalign_q, misalign_d, req_c;
  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_q + 32'd4;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    id_pc_d = id_pc_q;
    id_pc4_d = id_pc4_q;
    misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
    req_c = 1'b0;
    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
      valid_d = 1'b0;
      // an in-flight response that has not arrived yet must be drained first
      state_d = ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid) ? S_DRAIN : S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          req_c = 1'b1;
          state_d = S_WAIT;
        end
        S_WAIT: if (imem_rvalid) begin
          instr_d = imem_rdata;
          id_pc_d = pc_q;
          id_pc4_d = pc_plus4;
          pc_d = pc_plus4;
          valid_d = 1'b1;
          state_d = S_FULL;
        end
        S_FULL: if (id_ready) begin
          req_c = 1'b1;
          valid_d = 1'b0;
          state_d = S_WAIT;
        end
        S_DRAIN: if (imem_rvalid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      id_pc_q <= 32'h0;
      id_pc4_q <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      id_pc_q <= id_pc_d;
      id_pc4_q <= id_pc4_d;
      misalign_q <= misalign_d;
    end
  end
  assign imem_req = req_c && rst_n;
  assign imem_addr = pc_q;
  assign id_valid = valid_q;
  assign id_instr = instr_q;
  assign id_pc = id_pc_q;
  assign id_pc_plus4 = id_pc4_q;
  assign pc_misalign = misalign_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with queued expectations checked by decode-side monitors
module tb_instr_fetch;
  typedef struct packed {logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4;} exp_t;
  logic clk = 0, rst_n = 0, id_ready = 0, redirect_valid = 0, ready2 = 0, spur = 0;
  logic [31:0] redirect_pc = 0;
  logic imem_req, imem_rvalid, id_valid, pc_misalign;
  logic [31:0] imem_addr, imem_rdata, id_instr, id_pc, id_pc_plus4;
  logic imem_req2, rvalid2 = 0, id_valid2, misalign2;
  logic [31:0] imem_addr2, paddr2 = 0, id_instr2, id_pc2, id_pc4_2;
  logic pend = 0;
  int left = 0, mem_lat = 1;
  logic [31:0] paddr = 0;
  int n_chk = 0, n_fail = 0;
  exp_t q1[$], q2[$];
  exp_t e1, e2;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1357_0000);
  endfunction
  instr_fetch u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc_misalign(pc_misalign)
  );
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rvalid(rvalid2), .imem_rdata(mem_word(paddr2)), .id_valid(id_valid2),
    .id_ready(ready2), .id_instr(id_instr2), .id_pc(id_pc2), .id_pc_plus4(id_pc4_2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .pc_misalign(misalign2)
  );
  // memory for the main DUT: configurable latency plus an injectable stray response
  always @(posedge clk) begin
    if (imem_req) begin
      pend <= 1'b1;
      paddr <= imem_addr;
      left <= mem_lat;
    end else if (pend) begin
      if (left == 1) pend <= 1'b0;
      else left <= left - 1;
    end
  end
  assign imem_rvalid = (pend && left == 1) || spur;
  assign imem_rdata = spur ? 32'hDEAD_BEEF : mem_word(paddr);
  always @(posedge clk) begin
    rvalid2 <= imem_req2;
    paddr2 <= imem_addr2;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic neg();
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (rst_n && id_valid && id_ready) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dut consume: got pc %h expected no instruction", id_pc);
      end else begin
        e1 = q1.pop_front();
        chk("dut id_instr", id_instr, e1.instr);
        chk("dut id_pc", id_pc, e1.pc);
        chk("dut id_pc_plus4", id_pc_plus4, e1.pc4);
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n && id_valid2 && ready2) begin
      if (q2.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wrap consume: got pc %h expected no instruction", id_pc2);
      end else begin
        e2 = q2.pop_front();
        chk("wrap id_instr", id_instr2, e2.instr);
        chk("wrap id_pc", id_pc2, e2.pc);
        chk("wrap id_pc_plus4", id_pc4_2, e2.pc4);
      end
    end
  end
  initial begin
    tick(); tick();
    neg();
    chk("reset imem_req", {31'b0, imem_req}, 32'd0);
    chk("reset id_valid", {31'b0, id_valid}, 32'd0);
    chk("reset id_instr", id_instr, 32'h0000_0013);
    chk("reset id_pc", id_pc, 32'h0);
    chk("reset id_pc_plus4", id_pc_plus4, 32'h0);
    chk("reset pc_misalign", {31'b0, pc_misalign}, 32'd0);
    // first fetch after release
    tick(); rst_n = 1;
    q1.push_back('{32'h0050_0093, 32'h0, 32'h4});
    neg();
    chk("c0 imem_req", {31'b0, imem_req}, 32'd1);
    chk("c0 imem_addr", imem_addr, 32'h0);
    tick(); neg();
    chk("c1 imem_req", {31'b0, imem_req}, 32'd0);
    chk("c1 id_valid", {31'b0, id_valid}, 32'd0);
    tick(); neg();
    chk("c2 id_valid", {31'b0, id_valid}, 32'd1);
    chk("c2 id_instr", id_instr, 32'h0050_0093);
    chk("c2 id_pc", id_pc, 32'h0);
    chk("c2 id_pc_plus4", id_pc_plus4, 32'h4);
    // hold in FULL, including a stray response that must be ignored
    for (int i = 0; i < 5; i++) begin
      tick(); spur = (i == 2); neg();
      chk("hold imem_req", {31'b0, imem_req}, 32'd0);
      chk("hold id_valid", {31'b0, id_valid}, 32'd1);
      chk("hold id_instr", id_instr, 32'h0050_0093);
    end
    tick(); spur = 0; id_ready = 1;
    q1.push_back('{32'h1357_0004, 32'h4, 32'h8});
    neg();
    chk("consume imem_req", {31'b0, imem_req}, 32'd1);
    chk("consume imem_addr", imem_addr, 32'h4);
    tick(); id_ready = 0;
    tick(); id_ready = 1; mem_lat = 2;
    neg();
    chk("req8 imem_addr", imem_addr, 32'h8);
    // redirect while the fetch at 8 is still outstanding
    tick(); id_ready = 0; redirect_valid = 1; redirect_pc = 32'h100;
    neg();
    chk("redir wait imem_req", {31'b0, imem_req}, 32'd0);
    tick(); redirect_valid = 0; mem_lat = 1;
    neg();
    chk("drain imem_req", {31'b0, imem_req}, 32'd0);
    chk("drain id_valid", {31'b0, id_valid}, 32'd0);
    tick();
    q1.push_back('{32'h1357_0100, 32'h100, 32'h104});
    neg();
    chk("redir imem_req", {31'b0, imem_req}, 32'd1);
    chk("redir imem_addr", imem_addr, 32'h100);
    tick(); tick(); id_ready = 1;
    tick(); id_ready = 0;
    q1.push_back('{32'h1357_0104, 32'h104, 32'h108});
    // misaligned redirect coinciding with consume
    tick(); id_ready = 1; redirect_valid = 1; redirect_pc = 32'h202;
    neg();
    chk("redir+ready imem_req", {31'b0, imem_req}, 32'd0);
    tick(); id_ready = 0; redirect_valid = 0;
    q1.push_back('{32'h1357_0200, 32'h200, 32'h204});
    neg();
    chk("misalign pulse", {31'b0, pc_misalign}, 32'd1);
    chk("misalign id_valid", {31'b0, id_valid}, 32'd0);
    chk("misalign imem_req", {31'b0, imem_req}, 32'd1);
    chk("misalign imem_addr", imem_addr, 32'h200);
    tick(); neg();
    chk("misalign clears", {31'b0, pc_misalign}, 32'd0);
    tick(); id_ready = 1; mem_lat = 2;
    // reset while waiting; response lands during reset and a stray one after
    tick(); id_ready = 0; rst_n = 0;
    neg();
    chk("rst wait imem_req", {31'b0, imem_req}, 32'd0);
    tick(); neg();
    chk("rst rvalid imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst rvalid id_valid", {31'b0, id_valid}, 32'd0);
    tick(); rst_n = 1; spur = 1; mem_lat = 1;
    q1.push_back('{32'h0050_0093, 32'h0, 32'h4});
    neg();
    chk("rerelease imem_req", {31'b0, imem_req}, 32'd1);
    chk("rerelease imem_addr", imem_addr, 32'h0);
    tick(); spur = 0;
    tick(); id_ready = 1;
    neg();
    chk("rerelease id_pc", id_pc, 32'h0);
    tick(); id_ready = 0;
    // wrap-around on the second instance
    tick(); rst_n = 0; ready2 = 1;
    tick(); tick(); rst_n = 1;
    q2.push_back('{32'hECA8_FFFC, 32'hFFFF_FFFC, 32'h0});
    q2.push_back('{32'h0050_0093, 32'h0, 32'h4});
    neg();
    chk("wrap imem_req", {31'b0, imem_req2}, 32'd1);
    chk("wrap imem_addr", imem_addr2, 32'hFFFF_FFFC);
    tick(); tick(); tick(); tick(); tick(); ready2 = 0;
    tick(); tick(); neg();
    chk("dut queue drained", q1.size(), 32'd0);
    chk("wrap queue drained", q2.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL mean a fetch request is issued this cycle at imem_addr.
REQ-005 imem_addr  output  32  SHALL carry the word-aligned fetch address.
REQ-006 imem_rvalid  input  1  SHALL mean imem_rdata holds the response to the one outstanding request.
REQ-007 imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-008 id_valid  output  1  SHALL mean id_instr/id_pc/id_pc_plus4 hold a valid instruction for decode and immediate generation.
REQ-009 id_ready  input  1  SHALL mean decode consumes the held instruction this cycle.
REQ-010 id_instr / id_pc / id_pc_plus4  output  32 each  SHALL carry instruction, its PC, and PC+4.
REQ-011 redirect_valid  input  1  SHALL mean a taken branch/jump; redirect_pc  input  32  SHALL be the target.
REQ-012 pc_misalign  output  1  SHALL pulse one cycle when redirect_pc[1:0] != 2'b00.

Function
REQ-013 FSM states SHALL be REQ, WAIT, FULL, DRAIN; at most one request outstanding at any time.
REQ-014 REQ: imem_req=1, imem_addr=pc; next state WAIT.
REQ-015 WAIT: on imem_rvalid, load imem_rdata into the output slot, id_pc=pc, id_pc_plus4=pc+4, pc<=pc+4; next FULL.
REQ-016 FULL: id_valid=1; on id_ready, issue request at pc the same cycle, clear slot, next WAIT; otherwise hold all outputs stable.
REQ-017 DRAIN: on imem_rvalid discard data; next REQ.
REQ-018 Redirect SHALL take priority over all other events: imem_req suppressed that cycle, pc<={redirect_pc[31:2],2'b00}, slot cleared (id_valid=0 next cycle).
REQ-019 Redirect next state: from REQ or FULL -> REQ; from WAIT or DRAIN with imem_rvalid same cycle -> REQ (response dropped); from WAIT or DRAIN without imem_rvalid -> DRAIN.
REQ-020 Redirect coinciding with id_ready in FULL SHALL still consume the held instruction (decode sees it) and issue no request.
REQ-021 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
REQ-022 Latency: with one-cycle memory, request at cycle t gives id_valid at t+2; steady-state throughput 1 instruction per 2 cycles.
REQ-023 imem_rvalid in REQ or FULL (no request outstanding) SHALL be ignored.

Reset
REQ-024 While rst_n=0 at a rising edge: state<=REQ, pc<=RESET_PC, id_valid<=0, id_instr<=32'h0000_0013 (NOP), id_pc<=0, id_pc_plus4<=0, pc_misalign<=0.
REQ-025 imem_req SHALL be 0 during any cycle with rst_n=0; first request at RESET_PC in the first cycle after release.
REQ-026 Reset mid-request SHALL abandon the outstanding response; a late imem_rvalid after reset SHALL be ignored in REQ (REQ-023).

Structure
REQ-027 Shared package SHALL hold the FSM state encoding, NOP constant 32'h0000_0013, and default RESET_PC.
REQ-028 No sub-module is required; PC register, FSM, and output slot SHALL live in instr_fetch.

Verification
REQ-029 Reset release, memory returns 32'h0050_0093 one cycle later -> imem_addr=0 at cycle 0, id_valid=1, id_instr=32'h0050_0093, id_pc=0, id_pc_plus4=4 at cycle 2.
REQ-030 id_ready held 0 for 5 cycles in FULL -> outputs stable, imem_req=0 throughout; id_ready=1 -> imem_req=1, imem_addr=4 same cycle.
REQ-031 Redirect to 32'h0000_0100 while in WAIT, rvalid one cycle later -> stale data discarded, next request at 32'h100, next id_pc=32'h100.
REQ-032 Redirect to 32'h0000_0202 -> pc_misalign=1 one cycle, next imem_addr=32'h0000_0200.
REQ-033 RESET_PC=32'hFFFF_FFFC, two instructions consumed -> second id_pc=32'h0000_0000, id_pc_plus4 of first = 0.
REQ-034 rst_n=0 asserted in WAIT, rvalid arrives during/after reset -> ignored; first id_pc after release = RESET_PC.
